// File: rtl/leg_pkg.sv
// Shared types and constants for the LEG fetch/issue path and its opcode decoders.
package leg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_F0    = 3'd1,
        ST_F1    = 3'd2,
        ST_F2    = 3'd3,
        ST_F3    = 3'd4,
        ST_CAPT  = 3'd5,
        ST_ISSUE = 3'd6,
        ST_HALT  = 3'd7
    } leg_fetch_state_t;

    // Byte positions inside one 4-byte LEG instruction
    localparam int LEG_B_OP  = 0;
    localparam int LEG_B_A1  = 1;
    localparam int LEG_B_A2  = 2;
    localparam int LEG_B_DST = 3;

    localparam int LEG_INSTR_BYTES = 4;

    // Operand-source flags live in the top two opcode bits
    localparam int IMM_A_BIT = 7;
    localparam int IMM_B_BIT = 6;

    localparam logic [5:0] LEG_HALT_CODE = 6'h3F;

    // Byte offset from pc that a fetch state reads; zero for non-fetch states
    function automatic logic [1:0] fetch_offset(input leg_fetch_state_t s);
        logic [1:0] off;
        off = 2'd0;
        case (s)
            ST_F0:   off = 2'(LEG_B_OP);
            ST_F1:   off = 2'(LEG_B_A1);
            ST_F2:   off = 2'(LEG_B_A2);
            ST_F3:   off = 2'(LEG_B_DST);
            default: off = 2'd0;
        endcase
        return off;
    endfunction

    function automatic logic is_fetch_state(input leg_fetch_state_t s);
        return (s == ST_F0) || (s == ST_F1) || (s == ST_F2) || (s == ST_F3);
    endfunction

endpackage

// File: rtl/leg_imm_decode.sv
// Opcode flag decode shared by the fetch sequencer and the execute-side decoder.
module leg_imm_decode
    import leg_pkg::*;
(
    input  logic [7:0] op_code,
    output logic       imm_a,
    output logic       imm_b,
    output logic       is_halt
);

    // Pure wiring of the operand-source flags plus HALT match on the low six bits
    always_comb begin
        imm_a   = op_code[IMM_A_BIT];
        imm_b   = op_code[IMM_B_BIT];
        is_halt = (op_code[5:0] == LEG_HALT_CODE);
    end

endmodule

// File: rtl/leg_fetch_sequencer.sv
// Multi-cycle fetch/issue controller: reads four program bytes, holds the
// instruction under a valid/ready handshake and owns the PC.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for run, no program reads
// F0..F3   | read byte k at pc+k; in Fk (k>=1) capture byte k-1
// CAPT     | capture the last (dest) byte, no read
// ISSUE    | exec_valid high, fields frozen until exec_ready
// HALT     | HALT retired; no reads, pc frozen, exit only through rst
module leg_fetch_sequencer
    import leg_pkg::*;
#(
    parameter int PC_WIDTH   = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    output logic                  prog_rd_en,
    output logic [PC_WIDTH-1:0]   prog_addr,
    input  logic [DATA_WIDTH-1:0] prog_data,
    output logic [7:0]            op_code,
    output logic [DATA_WIDTH-1:0] arg1,
    output logic [DATA_WIDTH-1:0] arg2,
    output logic [DATA_WIDTH-1:0] dest,
    output logic                  imm_a,
    output logic                  imm_b,
    output logic                  exec_valid,
    input  logic                  exec_ready,
    input  logic                  branch_taken,
    input  logic [PC_WIDTH-1:0]   branch_target,
    output logic [PC_WIDTH-1:0]   pc,
    output logic                  halted
);

    leg_fetch_state_t      state_q;
    leg_fetch_state_t      state_d;
    logic [PC_WIDTH-1:0]   pc_d;
    logic                  rd_en_d;
    logic [PC_WIDTH-1:0]   addr_d;
    logic                  is_halt;
    logic                  xfer;

    leg_imm_decode u_imm_decode (
        .op_code (op_code),
        .imm_a   (imm_a),
        .imm_b   (imm_b),
        .is_halt (is_halt)
    );

    // exec_valid mirrors ISSUE, so the handshake never depends combinationally on exec_ready
    assign xfer = (state_q == ST_ISSUE) && exec_ready;

    // Next state, next pc, and the read strobe/address the next state will present
    always_comb begin
        state_d = state_q;
        pc_d    = pc;
        case (state_q)
            ST_IDLE:  if (run) state_d = ST_F0;
            ST_F0:    state_d = ST_F1;
            ST_F1:    state_d = ST_F2;
            ST_F2:    state_d = ST_F3;
            ST_F3:    state_d = ST_CAPT;
            ST_CAPT:  state_d = ST_ISSUE;
            ST_ISSUE: begin
                if (xfer) begin
                    if (is_halt) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_F0;
                        pc_d    = branch_taken ? branch_target
                                               : pc + PC_WIDTH'(LEG_INSTR_BYTES);
                    end
                end
            end
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_IDLE;
        endcase
        rd_en_d = is_fetch_state(state_d);
        addr_d  = rd_en_d ? pc_d + PC_WIDTH'(fetch_offset(state_d)) : prog_addr;
    end

    // State, pc, registered outputs and instruction field capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc         <= '0;
            prog_rd_en <= 1'b0;
            prog_addr  <= '0;
            op_code    <= '0;
            arg1       <= '0;
            arg2       <= '0;
            dest       <= '0;
            exec_valid <= 1'b0;
            halted     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc         <= pc_d;
            prog_rd_en <= rd_en_d;
            prog_addr  <= addr_d;
            exec_valid <= (state_d == ST_ISSUE);
            if (xfer && is_halt) halted <= 1'b1;
            // Read data trails the strobe by one cycle, so each state captures the previous byte
            case (state_q)
                ST_F1:   op_code <= prog_data[7:0];
                ST_F2:   arg1    <= prog_data;
                ST_F3:   arg2    <= prog_data;
                ST_CAPT: dest    <= prog_data;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_leg_fetch_sequencer.sv
// Self-checking bench for leg_fetch_sequencer: directed fetch/backpressure/
// branch/wrap/halt/reset cases followed by randomized handshakes and branches.
module tb_leg_fetch_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       prog_rd_en;
    logic [7:0] prog_addr;
    logic [7:0] prog_data;
    logic [7:0] op_code;
    logic [7:0] arg1;
    logic [7:0] arg2;
    logic [7:0] dest;
    logic       imm_a;
    logic       imm_b;
    logic       exec_valid;
    logic       exec_ready;
    logic       branch_taken;
    logic [7:0] branch_target;
    logic [7:0] pc;
    logic       halted;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] rom [256];
    logic [7:0] exp_pc;

    leg_fetch_sequencer #(.PC_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .run           (run),
        .prog_rd_en    (prog_rd_en),
        .prog_addr     (prog_addr),
        .prog_data     (prog_data),
        .op_code       (op_code),
        .arg1          (arg1),
        .arg2          (arg2),
        .dest          (dest),
        .imm_a         (imm_a),
        .imm_b         (imm_b),
        .exec_valid    (exec_valid),
        .exec_ready    (exec_ready),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc            (pc),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    // Program ROM: one-cycle read latency, garbage on the bus when not strobed
    always @(posedge clk) begin
        if (prog_rd_en) prog_data <= rom[prog_addr];
        else            prog_data <= 8'($urandom);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Instruction fields expected from the model pc and ROM image
    task automatic chk_fields(input string pre);
        logic [7:0] a0, a1, a2, a3;
        a0 = exp_pc;
        a1 = exp_pc + 8'd1;
        a2 = exp_pc + 8'd2;
        a3 = exp_pc + 8'd3;
        chk({pre, "_op"},    op_code, rom[a0]);
        chk({pre, "_arg1"},  arg1,    rom[a1]);
        chk({pre, "_arg2"},  arg2,    rom[a2]);
        chk({pre, "_dest"},  dest,    rom[a3]);
        chk({pre, "_imm_a"}, imm_a,   rom[a0][7]);
        chk({pre, "_imm_b"}, imm_b,   rom[a0][6]);
        chk({pre, "_pc"},    pc,      exp_pc);
    endtask

    task automatic apply_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
        exp_pc = 8'h00;
    endtask

    // One instruction: fetch, issue, optional backpressure, transfer.
    // Called at a negedge; first=1 when run was just raised in IDLE.
    task automatic do_instr(input bit first, input int delay, input bit br, input logic [7:0] tgt);
        logic [7:0] rd_q [$];
        int         cnt;
        bit         got;
        bit         will_halt;
        logic [7:0] a;
        cnt = first ? 0 : 1;
        got = 1'b0;
        if (!first && prog_rd_en) rd_q.push_back(prog_addr);
        for (int g = 0; g < 20; g++) begin
            @(negedge clk);
            cnt++;
            run           = 1'b0;
            exec_ready    = 1'($urandom);
            branch_taken  = 1'($urandom);
            branch_target = 8'($urandom);
            if (prog_rd_en) rd_q.push_back(prog_addr);
            if (exec_valid) begin
                got = 1'b1;
                break;
            end
        end
        chk("valid_seen", got, 1'b1);
        if (!got) return;
        chk("latency", cnt, 6);
        chk("n_reads", rd_q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            a = exp_pc + 8'(k);
            if (k < rd_q.size()) chk("rd_addr", rd_q[k], a);
        end
        chk_fields("issue");
        for (int d = 0; d < delay; d++) begin
            exec_ready    = 1'b0;
            branch_taken  = 1'($urandom);
            branch_target = 8'($urandom);
            @(negedge clk);
            chk("hold_valid", exec_valid, 1'b1);
            chk("hold_rd_en", prog_rd_en, 1'b0);
            chk_fields("hold");
        end
        will_halt     = (rom[exp_pc][5:0] == 6'h3F);
        exec_ready    = 1'b1;
        branch_taken  = br;
        branch_target = tgt;
        @(negedge clk);
        exec_ready    = 1'b0;
        branch_taken  = 1'b0;
        chk("valid_drop", exec_valid, 1'b0);
        chk("halted", halted, will_halt);
        if (!will_halt) exp_pc = br ? tgt : exp_pc + 8'd4;
        chk("pc_next", pc, exp_pc);
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] h_addr;
        bit         saw;
        rst           = 1'b1;
        run           = 1'b0;
        exec_ready    = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 8'h00;
        exp_pc        = 8'h00;
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;

        // Reset and idle
        @(negedge clk);
        apply_reset(2);
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (prog_rd_en || exec_valid) saw = 1'b1;
        end
        chk("idle_activity", saw, 1'b0);
        chk("idle_pc", pc, 8'h00);
        chk("idle_op", op_code, 8'h00);
        chk("idle_args", {arg1, arg2, dest}, 24'h0);
        chk("idle_imm", {imm_a, imm_b}, 2'b00);
        chk("idle_halted", halted, 1'b0);

        // Directed program image
        rom[8'h00] = 8'hC0; rom[8'h01] = 8'h05; rom[8'h02] = 8'h07; rom[8'h03] = 8'h03;
        rom[8'h04] = 8'h41; rom[8'h05] = 8'h11; rom[8'h06] = 8'h22; rom[8'h07] = 8'h33;
        rom[8'h20] = 8'h82; rom[8'h21] = 8'hAA; rom[8'h22] = 8'hBB; rom[8'h23] = 8'hCC;
        rom[8'hFC] = 8'h01; rom[8'hFD] = 8'h02; rom[8'hFE] = 8'h03; rom[8'hFF] = 8'h04;

        run = 1'b1;
        do_instr(1'b1, 0, 1'b0, 8'h00);   // basic fetch at 0, next pc 4
        chk("basic_imm", {imm_a, imm_b}, 2'b11);
        do_instr(1'b0, 5, 1'b1, 8'h20);   // backpressure, then branch to 20
        do_instr(1'b0, 1, 1'b1, 8'hFC);   // branch to FC
        do_instr(1'b0, 0, 1'b0, 8'h00);   // FC..FF, wraps to 00
        do_instr(1'b0, 0, 1'b1, 8'hFE);   // branch to FE
        do_instr(1'b0, 2, 1'b0, 8'h00);   // FE,FF,00,01 -> pc 02

        // Randomized program, no HALT opcodes
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom);
            if (b[5:0] == 6'h3F) b[0] = 1'b0;
            rom[i] = b;
        end
        for (int n = 0; n < 40; n++) begin
            do_instr(1'b0, $urandom_range(0, 3), ($urandom_range(0, 3) == 0), 8'($urandom));
        end

        // HALT far from the in-flight fetch window
        h_addr = exp_pc + 8'h80;
        rom[h_addr] = 8'h3F;
        do_instr(1'b0, 0, 1'b1, h_addr);
        do_instr(1'b0, 1, 1'b0, 8'h00);
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            run          = 1'($urandom);
            exec_ready   = 1'($urandom);
            branch_taken = 1'($urandom);
            @(negedge clk);
            if (prog_rd_en || exec_valid || !halted || pc !== h_addr) saw = 1'b1;
        end
        chk("halt_quiet", saw, 1'b0);

        // Reset out of HALT, then reset again in the middle of a fetch
        run          = 1'b0;
        exec_ready   = 1'b1;
        branch_taken = 1'b0;
        apply_reset(2);
        chk("rst_clears_halt", halted, 1'b0);
        run = 1'b1;
        repeat (3) @(negedge clk);
        run = 1'b0;
        chk("midop_rd_en", prog_rd_en, 1'b1);
        chk("midop_addr", prog_addr, 8'h02);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_pc", pc, 8'h00);
        chk("midrst_rd_en", prog_rd_en, 1'b0);
        chk("midrst_addr", prog_addr, 8'h00);
        chk("midrst_fields", {op_code, arg1, arg2, dest}, 32'h0);
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (exec_valid || prog_rd_en) saw = 1'b1;
        end
        chk("midrst_no_issue", saw, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time limit in case the sequence above stalls
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "time limit reached");
    end

endmodule
